adc_monitor_stats: RTL and testbench

- Downstream consumer of the current-monitor ADC front end: takes its `adc_data_valid`/`adc_data_value` sample stream and produces three things:
  - a block-averaged current value;
  - running min/max and a sample count;
  - a debounced over-current trip, based on N consecutive over-limit samples.
- Outputs feed the I2C register map. Published values freeze while an I2C read is in progress, so multi-byte reads stay coherent.

---
 rtl/adc_monitor_stats.sv | 169 ++++++++++++++++
 tb/tb_adc_monitor_stats.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_monitor_stats.sv
// ADC current-monitor statistics: block average, running min/max/count and a
// debounced over-current trip. Published values hold while an I2C read is active.
module adc_monitor_stats #(
  parameter int AVG_LOG2   = 3,
  parameter int TRIP_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_data_valid,
  input  logic [15:0] adc_data_value,
  input  logic        dds_cw_mode_select,
  input  logic [15:0] dds_current_limit,
  input  logic [15:0] cw_current_limit,
  input  logic        stats_clear,
  input  logic        i2c_read_busy,
  output logic        avg_valid,
  output logic [15:0] avg_value,
  output logic [15:0] min_value,
  output logic [15:0] max_value,
  output logic [15:0] sample_count,
  output logic        trip,
  output logic        trip_mode,
  output logic        avg_overrun
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int BLK_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]       TRIP_MAX = 8'(TRIP_COUNT);

  logic             r_valid_d;
  logic             r_mode_d;
  logic [15:0]      r_min;
  logic [15:0]      r_max;
  logic [15:0]      r_count;
  logic [ACC_W-1:0] r_acc;
  logic [BLK_W-1:0] r_blk;
  logic             r_pending;
  logic [15:0]      r_pend_val;
  logic [7:0]       r_run;
  logic             r_trip;
  logic             r_trip_mode;
  logic             r_overrun;

  logic             r_avg_valid;
  logic [15:0]      r_avg_value;
  logic [15:0]      r_min_pub;
  logic [15:0]      r_max_pub;
  logic [15:0]      r_count_pub;

  logic             w_accept;
  logic             w_over;
  logic             w_mode_chg;
  logic             w_blk_done;
  logic             w_publish;
  logic [15:0]      w_limit;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_avg_full;
  logic [15:0]      w_avg;
  logic [7:0]       w_run_next;
  logic             w_trip_hit;

  // A held-high valid level is accepted only on its rising cycle.
  assign w_accept   = adc_data_valid & ~r_valid_d;
  assign w_limit    = dds_cw_mode_select ? cw_current_limit : dds_current_limit;
  assign w_over     = adc_data_value > w_limit;
  assign w_mode_chg = dds_cw_mode_select ^ r_mode_d;
  assign w_blk_done = w_accept & (r_blk == BLK_LAST);
  assign w_publish  = ~i2c_read_busy;
  assign w_sum      = r_acc + ACC_W'(adc_data_value);
  assign w_avg_full = w_sum >> AVG_LOG2;
  assign w_avg      = w_avg_full[15:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_run_next = w_mode_chg ? 8'd0 : r_run;
    if (w_accept) begin
      if (!w_over)                   w_run_next = 8'd0;
      else if (w_run_next != TRIP_MAX) w_run_next = w_run_next + 8'd1;
    end
  end

  assign w_trip_hit = w_accept & w_over & (w_run_next == TRIP_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_d   <= 1'b0;
      r_mode_d    <= 1'b0;
      r_min       <= 16'hFFFF;
      r_max       <= 16'h0000;
      r_count     <= 16'h0000;
      r_acc       <= '0;
      r_blk       <= '0;
      r_pending   <= 1'b0;
      r_pend_val  <= 16'h0000;
      r_run       <= 8'd0;
      r_trip      <= 1'b0;
      r_trip_mode <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid_d <= adc_data_valid;
      r_mode_d  <= dds_cw_mode_select;
      if (stats_clear) begin
        r_min       <= 16'hFFFF;
        r_max       <= 16'h0000;
        r_count     <= 16'h0000;
        r_acc       <= '0;
        r_blk       <= '0;
        r_pending   <= 1'b0;
        r_run       <= 8'd0;
        r_trip      <= 1'b0;
        r_trip_mode <= 1'b0;
        r_overrun   <= 1'b0;
      end else begin
        r_run <= w_run_next;
        if (w_trip_hit && !r_trip) begin
          r_trip      <= 1'b1;
          r_trip_mode <= dds_cw_mode_select;
        end
        // Publication consumes the pending average; a completing block below overrides.
        if (w_publish && r_pending) r_pending <= 1'b0;
        if (w_accept) begin
          if (adc_data_value < r_min) r_min <= adc_data_value;
          if (adc_data_value > r_max) r_max <= adc_data_value;
          if (r_count != 16'hFFFF)    r_count <= r_count + 16'd1;
          if (w_blk_done) begin
            r_acc      <= '0;
            r_blk      <= '0;
            r_pend_val <= w_avg;
            r_pending  <= 1'b1;
            if (r_pending && !w_publish) r_overrun <= 1'b1;
          end else begin
            r_acc <= w_sum;
            r_blk <= r_blk + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_avg_valid <= 1'b0;
      r_avg_value <= 16'h0000;
      r_min_pub   <= 16'hFFFF;
      r_max_pub   <= 16'h0000;
      r_count_pub <= 16'h0000;
    end else if (w_publish) begin
      r_min_pub   <= r_min;
      r_max_pub   <= r_max;
      r_count_pub <= r_count;
      r_avg_valid <= r_pending;
      if (r_pending) r_avg_value <= r_pend_val;
    end else begin
      r_avg_valid <= 1'b0;
    end
  end

  assign avg_valid    = r_avg_valid;
  assign avg_value    = r_avg_value;
  assign min_value    = r_min_pub;
  assign max_value    = r_max_pub;
  assign sample_count = r_count_pub;
  assign trip         = r_trip;
  assign trip_mode    = r_trip_mode;
  assign avg_overrun  = r_overrun;

endmodule

// File: tb/tb_adc_monitor_stats.sv
// Directed bench for adc_monitor_stats: averaging, stats, debounce, freeze, clear, reset.
// A second instance with AVG_LOG2 = 0 covers the one-sample-per-block case.
module tb_adc_monitor_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_data_valid = 1'b0;
  logic [15:0] adc_data_value = 16'h0;
  logic        dds_cw_mode_select = 1'b0;
  logic [15:0] dds_current_limit = 16'hFFFF;
  logic [15:0] cw_current_limit = 16'hFFFF;
  logic        stats_clear = 1'b0;
  logic        i2c_read_busy = 1'b0;

  logic        avg_valid, trip, trip_mode, avg_overrun;
  logic [15:0] avg_value, min_value, max_value, sample_count;
  logic        avg_valid0, trip0, trip_mode0, avg_overrun0;
  logic [15:0] avg_value0, min_value0, max_value0, sample_count0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base;

  always #5 clk = ~clk;

  adc_monitor_stats #(.AVG_LOG2(3), .TRIP_COUNT(4)) u_dut (
    .clk(clk), .rst(rst),
    .adc_data_valid(adc_data_valid), .adc_data_value(adc_data_value),
    .dds_cw_mode_select(dds_cw_mode_select),
    .dds_current_limit(dds_current_limit), .cw_current_limit(cw_current_limit),
    .stats_clear(stats_clear), .i2c_read_busy(i2c_read_busy),
    .avg_valid(avg_valid), .avg_value(avg_value),
    .min_value(min_value), .max_value(max_value), .sample_count(sample_count),
    .trip(trip), .trip_mode(trip_mode), .avg_overrun(avg_overrun)
  );

  adc_monitor_stats #(.AVG_LOG2(0), .TRIP_COUNT(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .adc_data_valid(adc_data_valid), .adc_data_value(adc_data_value),
    .dds_cw_mode_select(dds_cw_mode_select),
    .dds_current_limit(dds_current_limit), .cw_current_limit(cw_current_limit),
    .stats_clear(stats_clear), .i2c_read_busy(i2c_read_busy),
    .avg_valid(avg_valid0), .avg_value(avg_value0),
    .min_value(min_value0), .max_value(max_value0), .sample_count(sample_count0),
    .trip(trip0), .trip_mode(trip_mode0), .avg_overrun(avg_overrun0)
  );

  always @(negedge clk) if (avg_valid) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; adc_data_valid = 1'b0; stats_clear = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  // Valid high for 'hold' cycles; returns at the negedge where valid drops.
  task automatic send(input logic [15:0] v, input int hold);
    @(negedge clk);
    adc_data_valid = 1'b1;
    adc_data_value = v;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    adc_data_valid = 1'b0;
  endtask

  task automatic send_n(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send(v, 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    idle(1);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_avg_value", avg_value, 0);
    check("rst_min", min_value, 16'hFFFF);
    check("rst_max", max_value, 0);
    check("rst_count", sample_count, 0);
    check("rst_trip", {trip, trip_mode, avg_overrun}, 0);

    // 1: one block 100..800, pulse two cycles after the last sample
    base = pulses;
    for (int i = 1; i <= 8; i++) send(16'(i * 100), 1);
    check("t1_no_pulse_yet", avg_valid, 0);
    idle(1);
    check("t1_avg_valid", avg_valid, 1);
    check("t1_avg_value", avg_value, 450);
    check("t1_min", min_value, 100);
    check("t1_max", max_value, 800);
    check("t1_count", sample_count, 8);
    check("t1_l0_valid", avg_valid0, 1);
    check("t1_l0_value", avg_value0, 800);
    idle(1);
    check("t1_pulse_end", avg_valid, 0);
    check("t1_pulses", pulses - base, 1);

    // 2: held valid counts once per sample
    do_reset();
    base = pulses;
    for (int i = 0; i < 3; i++) send(50, 5);
    idle(2);
    check("t2_count3", sample_count, 3);
    check("t2_no_avg", pulses - base, 0);
    for (int i = 0; i < 5; i++) send(50, 5);
    idle(2);
    check("t2_avg", avg_value, 50);
    check("t2_count8", sample_count, 8);
    check("t2_pulses", pulses - base, 1);

    // 3: trip debounce
    do_reset();
    dds_current_limit = 500; cw_current_limit = 500; dds_cw_mode_select = 1'b0;
    send_n(600, 3);
    check("t3_no_trip_3", trip, 0);
    send(400, 1);
    send_n(600, 3);
    check("t3_no_trip_7", trip, 0);
    send(600, 1);
    check("t3_trip_8", trip, 1);
    check("t3_trip_mode0", trip_mode, 0);

    do_reset();
    send_n(600, 3);
    @(negedge clk) dds_cw_mode_select = 1'b1;
    send(600, 1);
    check("t3_flip_no_trip", trip, 0);
    send_n(600, 2);
    check("t3_flip_no_trip3", trip, 0);
    send(600, 1);
    check("t3_flip_trip", trip, 1);
    check("t3_trip_mode1", trip_mode, 1);

    do_reset();
    dds_cw_mode_select = 1'b0;
    send_n(500, 5);
    check("t3_boundary", trip, 0);

    // 4: freeze across two blocks, one pulse on busy fall
    do_reset();
    dds_current_limit = 16'hFFFF; cw_current_limit = 16'hFFFF;
    i2c_read_busy = 1'b1;
    base = pulses;
    send_n(10, 8);
    send_n(20, 8);
    idle(2);
    check("t4_overrun", avg_overrun, 1);
    check("t4_frozen_min", min_value, 16'hFFFF);
    check("t4_frozen_count", sample_count, 0);
    check("t4_frozen_avg", avg_value, 0);
    check("t4_no_pulse", pulses - base, 0);
    i2c_read_busy = 1'b0;
    idle(1);
    check("t4_valid", avg_valid, 1);
    check("t4_avg", avg_value, 20);
    check("t4_min", min_value, 10);
    check("t4_max", max_value, 20);
    check("t4_count", sample_count, 16);
    idle(4);
    check("t4_single_pulse", pulses - base, 1);

    // 5: clear coincident with a sample after trip and overrun
    do_reset();
    dds_current_limit = 500; cw_current_limit = 500;
    i2c_read_busy = 1'b1;
    send_n(600, 16);
    check("t5_pre_trip", trip, 1);
    check("t5_pre_overrun", avg_overrun, 1);
    i2c_read_busy = 1'b0;
    idle(3);
    adc_data_valid = 1'b1; adc_data_value = 900; stats_clear = 1'b1;
    @(negedge clk);
    adc_data_valid = 1'b0; stats_clear = 1'b0;
    idle(2);
    check("t5_trip", trip, 0);
    check("t5_overrun", avg_overrun, 0);
    check("t5_min", min_value, 16'hFFFF);
    check("t5_max", max_value, 0);
    check("t5_count", sample_count, 0);
    send(30, 1);
    idle(2);
    check("t5_after_count", sample_count, 1);
    check("t5_after_max", max_value, 30);

    // 6: reset mid-block discards the partial block
    do_reset();
    dds_current_limit = 16'hFFFF; cw_current_limit = 16'hFFFF;
    send_n(1000, 5);
    do_reset();
    idle(1);
    check("t6_rst_count", sample_count, 0);
    base = pulses;
    send_n(7, 7);
    idle(3);
    check("t6_no_early_avg", pulses - base, 0);
    send(7, 1);
    idle(1);
    check("t6_valid", avg_valid, 1);
    check("t6_avg", avg_value, 7);
    check("t6_count", sample_count, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
